topk_insert_buffer: RTL

- Downstream neighbour of the memory controller and BDU array: consumes (distance, point_id) candidates shifted out of the BDUs during the drain phase.
- Keeps a per-query list of the K nearest reference points, sorted ascending by distance.
- Presents the list as the knn buffer that the memory controller writes back to memory in its write-back phase.
- Cleared at the start of every query.

---
 rtl/topk_insert_buffer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/topk_insert_buffer.sv
// topk_insert_buffer: keeps the K nearest (distance, point_id) candidates of
// the current query as a list sorted ascending by distance. Each candidate
// is inserted with one parallel compare-and-shift per clock. A new entry is
// placed after any existing entries of equal distance, so earlier arrivals
// win ties. All outputs come straight from registers.
module topk_insert_buffer #(
  parameter int K          = 8,
  parameter int DIST_WIDTH = 32,
  parameter int ID_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      cand_valid,
  input  logic [DIST_WIDTH-1:0]     cand_dist,
  input  logic [ID_WIDTH-1:0]       cand_id,
  output logic [K*DIST_WIDTH-1:0]   knn_dist_out,
  output logic [K*ID_WIDTH-1:0]     knn_id_out,
  output logic [K-1:0]              knn_valid_out,
  output logic [$clog2(K+1)-1:0]    count,
  output logic                      full,
  output logic [DIST_WIDTH-1:0]     worst_dist,
  output logic                      inserted
);

  localparam int CW = $clog2(K+1);
  localparam logic [CW-1:0]         K_CNT      = CW'(K);
  localparam logic [CW-1:0]         ONE_CNT    = CW'(1);
  localparam logic [CW-1:0]         ZERO_CNT   = CW'(0);
  localparam logic [DIST_WIDTH-1:0] DIST_EMPTY = {DIST_WIDTH{1'b1}};
  localparam logic [ID_WIDTH-1:0]   ID_EMPTY   = {ID_WIDTH{1'b0}};

  // Registered list state
  logic [DIST_WIDTH-1:0] dist_r [K];
  logic [ID_WIDTH-1:0]   id_r   [K];
  logic [K-1:0]          valid_r;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic [DIST_WIDTH-1:0] worst_r;
  logic                  inserted_r;

  // Next-state values
  logic [DIST_WIDTH-1:0] dist_n_s [K];
  logic [ID_WIDTH-1:0]   id_n_s   [K];
  logic [K-1:0]          valid_n_s;
  logic [CW-1:0]         count_n_s;
  logic                  full_n_s;
  logic [DIST_WIDTH-1:0] worst_n_s;
  logic                  inserted_n_s;

  // Compare vector and insert position
  logic [K-1:0]          lt_s;
  logic                  found_s;
  int                    pos_s;

  // Per-slot strict less-than compare; an empty slot acts as +infinity.
  always_comb begin
    lt_s = {K{1'b0}};
    for (int i = 0; i < K; i++) begin
      lt_s[i] = !valid_r[i] || (cand_dist < dist_r[i]);
    end
  end

  // Priority-select the lowest slot whose compare fired.
  always_comb begin
    pos_s = K;
    for (int i = K - 1; i >= 0; i--) begin
      if (lt_s[i]) begin
        pos_s = i;
      end else begin
        pos_s = pos_s;
      end
    end
    found_s = |lt_s;
  end

  // Next list contents: clear/restart, shift-insert, or hold.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      dist_n_s[i] = dist_r[i];
      id_n_s[i]   = id_r[i];
    end
    valid_n_s    = valid_r;
    count_n_s    = count_r;
    inserted_n_s = 1'b0;

    if (clear) begin
      for (int i = 0; i < K; i++) begin
        dist_n_s[i] = DIST_EMPTY;
        id_n_s[i]   = ID_EMPTY;
      end
      valid_n_s = {K{1'b0}};
      if (cand_valid) begin
        // First candidate of the new query lands directly in slot 0.
        dist_n_s[0]  = cand_dist;
        id_n_s[0]    = cand_id;
        valid_n_s[0] = 1'b1;
        count_n_s    = ONE_CNT;
        inserted_n_s = 1'b1;
      end else begin
        count_n_s    = ZERO_CNT;
        inserted_n_s = 1'b0;
      end
    end else if (cand_valid && found_s) begin
      if (pos_s == 0) begin
        dist_n_s[0]  = cand_dist;
        id_n_s[0]    = cand_id;
        valid_n_s[0] = 1'b1;
      end else begin
        dist_n_s[0]  = dist_r[0];
        id_n_s[0]    = id_r[0];
        valid_n_s[0] = valid_r[0];
      end
      // Slots above the insert point move down by one; old slot K-1 falls off.
      for (int i = 1; i < K; i++) begin
        if (i > pos_s) begin
          dist_n_s[i]  = dist_r[i-1];
          id_n_s[i]    = id_r[i-1];
          valid_n_s[i] = valid_r[i-1];
        end else if (i == pos_s) begin
          dist_n_s[i]  = cand_dist;
          id_n_s[i]    = cand_id;
          valid_n_s[i] = 1'b1;
        end else begin
          dist_n_s[i]  = dist_r[i];
          id_n_s[i]    = id_r[i];
          valid_n_s[i] = valid_r[i];
        end
      end
      if (full_r) begin
        count_n_s = count_r;
      end else begin
        count_n_s = count_r + ONE_CNT;
      end
      inserted_n_s = 1'b1;
    end else begin
      count_n_s    = count_r;
      inserted_n_s = 1'b0;
    end

    full_n_s  = (count_n_s == K_CNT);
    worst_n_s = full_n_s ? dist_n_s[K-1] : DIST_EMPTY;
  end

  // State registers with async reset; clear is handled in the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        dist_r[i] <= DIST_EMPTY;
        id_r[i]   <= ID_EMPTY;
      end
      valid_r    <= {K{1'b0}};
      count_r    <= ZERO_CNT;
      full_r     <= 1'b0;
      worst_r    <= DIST_EMPTY;
      inserted_r <= 1'b0;
    end else begin
      for (int i = 0; i < K; i++) begin
        dist_r[i] <= dist_n_s[i];
        id_r[i]   <= id_n_s[i];
      end
      valid_r    <= valid_n_s;
      count_r    <= count_n_s;
      full_r     <= full_n_s;
      worst_r    <= worst_n_s;
      inserted_r <= inserted_n_s;
    end
  end

  // Pack the registered slots onto the flat output buses.
  for (genvar g = 0; g < K; g++) begin : g_pack
    assign knn_dist_out[g*DIST_WIDTH +: DIST_WIDTH] = dist_r[g];
    assign knn_id_out[g*ID_WIDTH +: ID_WIDTH]       = id_r[g];
  end

  assign knn_valid_out = valid_r;
  assign count         = count_r;
  assign full          = full_r;
  assign worst_dist    = worst_r;
  assign inserted      = inserted_r;

endmodule
